spi_frame_listener: RTL and testbench
=====================================

# spi_frame_listener

Parametrised successor to the SPI byte listener. Collects byte strobes from the SPI slave core and assembles them into `BYTES`-wide frames in selectable byte order. A per-frame inter-byte timeout discards partial frames. Completed frames are buffered in a small FIFO with a ready/valid output, and a one-cycle interrupt fires per stored frame. Sits between the SPI slave byte receiver and the command decoder / CPU interrupt logic.

## Interface
- `BYTES`, default 3: bytes per frame, ≥ 2.
- `TO_CYCLES`, default 100: idle clocks allowed between bytes of one frame, ≥ 1, < 2^`TO_W`.
- `TO_W`, default 16: timeout counter width.
- `DEPTH`, default 4: frame FIFO depth, power of two, ≥ 2.
- `MSB_FIRST`, default 1: 1 = first byte lands in the top byte of the frame; 0 = first byte lands in the bottom byte.

Ports:
- `clk`  in  1: single clock; all logic rises on `posedge clk`.
- `rst`  in  1: asynchronous, active-high reset.
- `spi_slave_data_valid`  in  1: byte strobe; each high cycle is one byte.
- `spi_slave_byte`  in  8: byte, sampled when the strobe is high.
- `spi_data`  out  8*BYTES: FIFO head frame.
- `frame_valid`  out  1: FIFO non-empty.
- `frame_ready`  in  1: pop the head when `frame_valid` is also high.
- `spi_listener_interrupt`  out  1: one-cycle pulse per frame stored.
- `timeout_cnt`  out  TO_W: current inter-byte idle count.
- `fifo_level`  out  $clog2(DEPTH)+1: number of frames stored.
- `timeout_err`  out  1: sticky; a partial frame was discarded.
- `overflow_err`  out  1: sticky; a complete frame was dropped because the FIFO was full.
- `err_clr`  in  1: clears both sticky flags.

## Operation
- Byte index `idx` counts 0..BYTES-1.
- Each strobe shifts the byte into the assembly register:
  - MSB_FIRST=1: `{asm[8*(BYTES-1)-1:0], byte}`.
  - MSB_FIRST=0: `{byte, asm[8*BYTES-1:8]}`.
  - `idx` increments.
- Strobe with `idx==BYTES-1` completes the frame:
  - The frame, including the current byte, is written to the FIFO at that same edge.
  - `idx` returns to 0.
- Timeout counter:
  - Held at 0 while `idx==0`.
  - Cleared by every strobe.
  - Otherwise increments each clock.
  - When it equals `TO_CYCLES` with no strobe in that cycle: `idx` goes to 0, the assembly register is cleared, `timeout_err` is set, and the counter goes to 0.
- A strobe in the same cycle the counter equals `TO_CYCLES` is accepted as a continuation byte. No timeout is taken.
- FIFO full at completion:
  - Frame is dropped, `overflow_err` is set, no interrupt.
  - Exception: if a pop happens in the same cycle, the push succeeds and the level is unchanged.
- Pop on an empty FIFO is ignored.
- Push and pop together on a non-empty FIFO: level is unchanged.
- `err_clr` clears the sticky flags. If an error event occurs in the same cycle, set wins.
- `rst` mid-frame discards the partial frame and all FIFO contents.

## Timing
- Reset values: `spi_data`=0, `frame_valid`=0, `spi_listener_interrupt`=0, `timeout_cnt`=0, `fifo_level`=0, `timeout_err`=0, `overflow_err`=0. Internally `idx`=0 and the FIFO pointers are 0.
- Latency: last-byte strobe in cycle N gives `frame_valid`=1, valid `spi_data`, and `spi_listener_interrupt`=1 in cycle N+1. The interrupt is low again in N+2.
- `spi_data` is the head combinationally from FIFO storage. It is stable while `frame_valid` is high and `frame_ready` is low.
- Pop in cycle N: the next head, or `frame_valid`=0, appears in N+1.
- Timeout: last strobe in cycle N gives `timeout_cnt`=k in cycle N+k. The discard happens at the edge ending cycle N+TO_CYCLES, and `timeout_err` is high from N+TO_CYCLES+1.
- Back-to-back strobes on consecutive cycles are fully supported.

## Test plan
- Defaults, 10 ns clock. Bytes a2, bb, cc spaced 10 cycles, `frame_ready`=0 -> `spi_data`=0xa2bbcc, `fifo_level`=1, one interrupt pulse 1 cycle after the cc strobe.
- Bytes 00, 20, then 200 idle cycles, then cc, 30, 20 -> `timeout_err`=1 at cycle 101 after 20. `timeout_cnt` peaks at 100, then is 0. The next frame is 0xcc3020; no frame contains 00 or 20 from the partial.
- MSB_FIRST=0, bytes a2, bb, cc -> `spi_data`=0xccbba2.
- DEPTH=4, 5 frames with `frame_ready`=0 -> `fifo_level`=4, `overflow_err`=1, 4 interrupts. Pop all with `frame_ready`=1 -> the first 4 frames come out in order, then `frame_valid`=0. Then `err_clr` -> `overflow_err`=0.
- Boundary and full cases:
  - Strobe in the exact cycle `timeout_cnt`=100 -> byte is appended, no `timeout_err`.
  - FIFO full, last byte coincident with a pop -> frame stored, level stays 4, `overflow_err` stays 0.
- `rst` pulse after 2 of 3 bytes while FIFO holds 2 frames -> all outputs return to reset values. The next 3 bytes 11, 22, 33 give exactly one frame, 0x112233.

Source files
------------

// File: rtl/spi_frame_listener.sv
// spi_frame_listener: assembles SPI byte strobes into frames with an inter-byte timeout and a ready/valid frame FIFO
module spi_frame_listener #(
  parameter int BYTES = 3,
  parameter int TO_CYCLES = 100,
  parameter int TO_W = 16,
  parameter int DEPTH = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_slave_data_valid,
  input  logic [7:0]              spi_slave_byte,
  output logic [8*BYTES-1:0]      spi_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    spi_listener_interrupt,
  output logic [TO_W-1:0]         timeout_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    timeout_err,
  output logic                    overflow_err,
  input  logic                    err_clr
);
  localparam int W = 8 * BYTES;
  localparam int IW = $clog2(BYTES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CYCLES);
  logic [IW-1:0] idx;
  logic [W-1:0] asm_q, frame;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic last, expire, full, pop, push_ok;
  assign fifo_level = wp - rp;
  assign frame_valid = wp != rp;
  assign spi_data = mem[rp[AW-1:0]];
  // shifted assembly value, frame completion, timeout expiry and FIFO handshake decode
  always_comb begin
    frame = (MSB_FIRST != 0) ? {asm_q[W-9:0], spi_slave_byte} : {spi_slave_byte, asm_q[W-1:8]};
    last = spi_slave_data_valid && idx == LAST_IDX;
    expire = !spi_slave_data_valid && idx != '0 && timeout_cnt == TO_LIM;
    full = fifo_level[AW];
    pop = frame_ready && frame_valid;
    push_ok = last && (!full || pop);
  end
  // byte assembly; the counter reads 1 in the cycle after a continuing strobe so it equals the idle distance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      asm_q <= '0;
      timeout_cnt <= '0;
    end else if (spi_slave_data_valid) begin
      asm_q <= frame;
      idx <= last ? '0 : idx + 1'b1;
      timeout_cnt <= last ? '0 : TO_W'(1);
    end else if (expire) begin
      idx <= '0;
      asm_q <= '0;
      timeout_cnt <= '0;
    end else if (idx != '0) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
  // frame FIFO; a pop in the same cycle frees the slot for a push into a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp[AW-1:0]] <= frame;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
  // interrupt pulse per stored frame and sticky error flags where a new event beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_listener_interrupt <= 1'b0;
      timeout_err <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      spi_listener_interrupt <= push_ok;
      timeout_err <= expire | (timeout_err & ~err_clr);
      overflow_err <= (last & full & ~pop) | (overflow_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_spi_frame_listener.sv
// tb_spi_frame_listener: directed and randomized checks of spi_frame_listener against a queue-based reference model
module tb_spi_frame_listener;
  localparam int BYTES = 3;
  localparam int TO = 100;
  localparam int DEPTH = 4;
  localparam int W = 8 * BYTES;
  logic clk = 0, rst = 1, spi_slave_data_valid = 0, frame_ready = 0, err_clr = 0;
  logic [7:0] spi_slave_byte = 0;
  logic [W-1:0] spi_data, spi_data_l;
  logic frame_valid, frame_valid_l, spi_listener_interrupt, irq_l;
  logic timeout_err, terr_l, overflow_err, oerr_l;
  logic [15:0] timeout_cnt, cnt_l;
  logic [2:0] fifo_level, level_l;
  int errors = 0, checks = 0, irq_seen = 0;
  logic [7:0] m_part[$];
  logic [W-1:0] m_qm[$], m_ql[$];
  int m_cnt = 0;
  bit m_irq = 0, m_terr = 0, m_oerr = 0;

  always #5 clk = ~clk;

  spi_frame_listener #(.BYTES(BYTES), .TO_CYCLES(TO), .TO_W(16), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .spi_slave_data_valid(spi_slave_data_valid), .spi_slave_byte(spi_slave_byte),
    .spi_data(spi_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .spi_listener_interrupt(spi_listener_interrupt), .timeout_cnt(timeout_cnt), .fifo_level(fifo_level),
    .timeout_err(timeout_err), .overflow_err(overflow_err), .err_clr(err_clr));

  spi_frame_listener #(.BYTES(BYTES), .TO_CYCLES(TO), .TO_W(16), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .spi_slave_data_valid(spi_slave_data_valid), .spi_slave_byte(spi_slave_byte),
    .spi_data(spi_data_l), .frame_valid(frame_valid_l), .frame_ready(frame_ready),
    .spi_listener_interrupt(irq_l), .timeout_cnt(cnt_l), .fifo_level(level_l),
    .timeout_err(terr_l), .overflow_err(oerr_l), .err_clr(err_clr));

  always @(posedge clk) if (spi_listener_interrupt) irq_seen++;

  // reference model: bytes of the partial frame in a queue, completed frames in queues, idle distance as a count
  always @(posedge clk or posedge rst) begin
    bit done, pop, terr_ev, oerr_ev;
    logic [W-1:0] fm, fl;
    if (rst) begin
      m_part.delete(); m_qm.delete(); m_ql.delete();
      m_cnt = 0; m_irq = 0; m_terr = 0; m_oerr = 0;
    end else begin
      done = 0; terr_ev = 0; oerr_ev = 0; fm = 0; fl = 0;
      pop = frame_ready && m_qm.size() > 0;
      if (spi_slave_data_valid) begin
        m_part.push_back(spi_slave_byte);
        if (m_part.size() == BYTES) begin
          for (int i = 0; i < BYTES; i++) begin
            fm = (fm << 8) | W'(m_part[i]);
            fl = fl | (W'(m_part[i]) << (8 * i));
          end
          m_part.delete();
          done = 1;
        end
        m_cnt = m_part.size() > 0 ? 1 : 0;
      end else if (m_part.size() > 0) begin
        if (m_cnt == TO) begin
          m_part.delete();
          m_cnt = 0;
          terr_ev = 1;
        end else m_cnt++;
      end
      if (pop) begin
        void'(m_qm.pop_front());
        void'(m_ql.pop_front());
      end
      m_irq = 0;
      if (done) begin
        if (m_qm.size() < DEPTH) begin
          m_qm.push_back(fm);
          m_ql.push_back(fl);
          m_irq = 1;
        end else oerr_ev = 1;
      end
      m_terr = terr_ev | (m_terr & !err_clr);
      m_oerr = oerr_ev | (m_oerr & !err_clr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    spi_slave_data_valid = 1;
    spi_slave_byte = b;
    tick();
    spi_slave_data_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_errs();
    err_clr = 1;
    tick();
    err_clr = 0;
  endtask

  task automatic drain();
    frame_ready = 1;
    for (int i = 0; i < 2 * DEPTH && frame_valid; i++) tick();
    frame_ready = 0;
  endtask

  task automatic test_reset();
    idle(2);
    rst = 0;
    tick();
    checks++; if (spi_data !== 0) begin errors++; $display("FAIL reset_data got %h exp 0", spi_data); end
    checks++; if (frame_valid !== 0) begin errors++; $display("FAIL reset_valid got %b exp 0", frame_valid); end
    checks++; if (spi_listener_interrupt !== 0) begin errors++; $display("FAIL reset_irq got %b exp 0", spi_listener_interrupt); end
    checks++; if (timeout_cnt !== 0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", timeout_cnt); end
    checks++; if (fifo_level !== 0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if ({timeout_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {timeout_err, overflow_err}); end
  endtask

  task automatic test_basic_frame();
    int base;
    frame_ready = 0;
    send(8'ha2); idle(9);
    send(8'hbb); idle(9);
    base = irq_seen;
    send(8'hcc);
    checks++; if (spi_listener_interrupt !== 1) begin errors++; $display("FAIL basic_irq got %b exp 1", spi_listener_interrupt); end
    checks++; if (frame_valid !== 1) begin errors++; $display("FAIL basic_valid got %b exp 1", frame_valid); end
    checks++; if (spi_data !== 24'ha2bbcc) begin errors++; $display("FAIL basic_data got %h exp a2bbcc", spi_data); end
    checks++; if (spi_data_l !== 24'hccbba2) begin errors++; $display("FAIL lsb_first_data got %h exp ccbba2", spi_data_l); end
    checks++; if (fifo_level !== 1) begin errors++; $display("FAIL basic_level got %0d exp 1", fifo_level); end
    idle(3);
    checks++; if (spi_listener_interrupt !== 0 || irq_seen - base !== 1) begin errors++; $display("FAIL basic_irq_pulse got %0d pulses exp 1", irq_seen - base); end
    checks++; if (spi_data !== 24'ha2bbcc) begin errors++; $display("FAIL basic_hold got %h exp a2bbcc", spi_data); end
    frame_ready = 1;
    tick();
    frame_ready = 0;
    checks++; if (frame_valid !== 0) begin errors++; $display("FAIL basic_pop got %b exp 0", frame_valid); end
  endtask

  task automatic test_timeout();
    int bad = 0;
    send(8'h00);
    send(8'h20);
    for (int k = 1; k <= TO; k++) begin
      if (timeout_cnt !== 16'(k) || timeout_err !== 0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL timeout_ramp got %0d bad cycles exp 0", bad); end
    checks++; if (timeout_err !== 1) begin errors++; $display("FAIL timeout_err got %b exp 1", timeout_err); end
    checks++; if (timeout_cnt !== 0) begin errors++; $display("FAIL timeout_cnt_after got %0d exp 0", timeout_cnt); end
    idle(99);
    send(8'hcc); send(8'h30); send(8'h20);
    checks++; if (fifo_level !== 1 || spi_data !== 24'hcc3020) begin errors++; $display("FAIL timeout_next got %h lvl %0d exp cc3020 lvl 1", spi_data, fifo_level); end
    drain();
    clear_errs();
    checks++; if (timeout_err !== 0) begin errors++; $display("FAIL timeout_clr got %b exp 0", timeout_err); end
  endtask

  task automatic test_timeout_boundary();
    send(8'h01);
    idle(TO - 1);
    checks++; if (timeout_cnt !== 16'(TO)) begin errors++; $display("FAIL boundary_cnt got %0d exp %0d", timeout_cnt, TO); end
    send(8'h02);
    checks++; if (timeout_err !== 0 || timeout_cnt !== 1) begin errors++; $display("FAIL boundary_accept got err %b cnt %0d exp err 0 cnt 1", timeout_err, timeout_cnt); end
    send(8'h03);
    checks++; if (spi_data !== 24'h010203 || fifo_level !== 1) begin errors++; $display("FAIL boundary_frame got %h exp 010203", spi_data); end
    drain();
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_f[5];
    logic [7:0] b;
    int base = irq_seen;
    frame_ready = 0;
    for (int f = 0; f < 5; f++) begin
      exp_f[f] = 0;
      for (int i = 0; i < BYTES; i++) begin
        b = 8'($urandom);
        exp_f[f] = (exp_f[f] << 8) | W'(b);
        send(b);
      end
    end
    idle(2);
    checks++; if (fifo_level !== 4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    checks++; if (overflow_err !== 1) begin errors++; $display("FAIL ovf_err got %b exp 1", overflow_err); end
    checks++; if (irq_seen - base !== 4) begin errors++; $display("FAIL ovf_irqs got %0d exp 4", irq_seen - base); end
    frame_ready = 1;
    for (int f = 0; f < 4; f++) begin
      checks++; if (frame_valid !== 1 || spi_data !== exp_f[f]) begin errors++; $display("FAIL ovf_pop%0d got %h exp %h", f, spi_data, exp_f[f]); end
      tick();
    end
    frame_ready = 0;
    checks++; if (frame_valid !== 0) begin errors++; $display("FAIL ovf_empty got %b exp 0", frame_valid); end
    clear_errs();
    checks++; if (overflow_err !== 0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow_err); end
  endtask

  task automatic test_full_with_pop();
    logic [W-1:0] exp_f[5];
    logic [7:0] b;
    frame_ready = 0;
    for (int f = 0; f < 5; f++) begin
      exp_f[f] = 0;
      for (int i = 0; i < BYTES; i++) begin
        b = 8'($urandom);
        exp_f[f] = (exp_f[f] << 8) | W'(b);
        if (f == 4 && i == BYTES - 1) frame_ready = 1;
        send(b);
        frame_ready = 0;
      end
    end
    checks++; if (fifo_level !== 4 || overflow_err !== 0 || spi_listener_interrupt !== 1) begin errors++; $display("FAIL fullpop got lvl %0d ovf %b irq %b exp 4 0 1", fifo_level, overflow_err, spi_listener_interrupt); end
    frame_ready = 1;
    for (int f = 1; f < 5; f++) begin
      checks++; if (spi_data !== exp_f[f]) begin errors++; $display("FAIL fullpop_order%0d got %h exp %h", f, spi_data, exp_f[f]); end
      tick();
    end
    frame_ready = 0;
    checks++; if (frame_valid !== 0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", frame_valid); end
  endtask

  task automatic test_rst_mid_frame();
    int base;
    frame_ready = 0;
    for (int i = 0; i < 2 * BYTES; i++) send(8'($urandom));
    send(8'h55); send(8'h66);
    rst = 1;
    #2;
    checks++; if ({spi_data, frame_valid, spi_listener_interrupt, timeout_cnt, fifo_level, timeout_err, overflow_err} !== '0) begin errors++; $display("FAIL rst_mid got data %h v %b cnt %0d lvl %0d exp all 0", spi_data, frame_valid, timeout_cnt, fifo_level); end
    tick();
    rst = 0;
    tick();
    base = irq_seen;
    send(8'h11); send(8'h22); send(8'h33);
    idle(1);
    checks++; if (fifo_level !== 1 || spi_data !== 24'h112233 || irq_seen - base !== 1) begin errors++; $display("FAIL rst_next got %h lvl %0d exp 112233 lvl 1", spi_data, fifo_level); end
    drain();
  endtask

  task automatic test_random();
    int rate, ready_pct;
    for (int c = 0; c < 4000; c++) begin
      rate = ((c / 300) % 3 == 2) ? 1 : 35;
      ready_pct = ((c / 200) % 2 == 1) ? 60 : 8;
      spi_slave_data_valid = $urandom_range(99) < rate;
      spi_slave_byte = 8'($urandom);
      frame_ready = $urandom_range(99) < ready_pct;
      err_clr = $urandom_range(99) < 2;
      tick();
      checks++; if (frame_valid !== (m_qm.size() > 0) || int'(fifo_level) != m_qm.size()) begin errors++; $display("FAIL rnd_level c%0d got %0d exp %0d", c, fifo_level, m_qm.size()); end
      if (m_qm.size() > 0) begin
        checks++; if (spi_data !== m_qm[0] || spi_data_l !== m_ql[0]) begin errors++; $display("FAIL rnd_data c%0d got %h/%h exp %h/%h", c, spi_data, spi_data_l, m_qm[0], m_ql[0]); end
      end
      checks++; if (int'(timeout_cnt) != m_cnt) begin errors++; $display("FAIL rnd_cnt c%0d got %0d exp %0d", c, timeout_cnt, m_cnt); end
      checks++; if ({spi_listener_interrupt, timeout_err, overflow_err} !== {m_irq, m_terr, m_oerr}) begin errors++; $display("FAIL rnd_flags c%0d got %b exp %b", c, {spi_listener_interrupt, timeout_err, overflow_err}, {m_irq, m_terr, m_oerr}); end
      checks++; if ({frame_valid_l, irq_l, terr_l, oerr_l, int'(level_l), int'(cnt_l)} !== {m_qm.size() > 0, m_irq, m_terr, m_oerr, m_qm.size(), m_cnt}) begin errors++; $display("FAIL rnd_lsb_ctrl c%0d lvl %0d cnt %0d", c, level_l, cnt_l); end
    end
    spi_slave_data_valid = 0;
    frame_ready = 0;
    err_clr = 0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_timeout();
    test_timeout_boundary();
    test_overflow();
    test_full_with_pop();
    test_rst_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
